// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight register writes with a Tnew countdown,
// raises stall, forwards ready results to the ID operands and interlocks the mult/div unit.
module hazard_scoreboard #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int TW     = 2,
    parameter int NSTAGE = 3,
    parameter int MD_LAT = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 id_valid,
    input  logic [AW-1:0]        id_rs,
    input  logic [AW-1:0]        id_rt,
    input  logic [TW-1:0]        id_rs_tuse,
    input  logic [TW-1:0]        id_rt_tuse,
    input  logic [AW-1:0]        id_wa,
    input  logic [TW-1:0]        id_tnew,
    input  logic                 id_md_start,
    input  logic                 id_md_use,
    input  logic                 flush,
    input  logic [NSTAGE*DW-1:0] stage_wd,
    input  logic [DW-1:0]        id_rd1_pre,
    input  logic [DW-1:0]        id_rd2_pre,
    output logic                 stall,
    output logic [DW-1:0]        id_rd1,
    output logic [DW-1:0]        id_rd2,
    output logic                 md_busy
);

    localparam logic [TW-1:0] TUSE_NONE = '1;

    logic [NSTAGE-1:0] v;
    logic [AW-1:0]     wa   [NSTAGE];
    logic [TW-1:0]     tnew [NSTAGE];
    logic [7:0]        md_cnt;

    logic          rs_hit, rt_hit;
    logic [TW-1:0] rs_tnew, rt_tnew;
    logic [DW-1:0] rs_data, rt_data;
    logic          rs_term, rt_term, md_stall;

    // Scan oldest to youngest so the youngest match overwrites and shadows older ones.
    always_comb begin
        rs_hit  = 1'b0;
        rt_hit  = 1'b0;
        rs_tnew = '0;
        rt_tnew = '0;
        rs_data = '0;
        rt_data = '0;
        for (int s = NSTAGE - 1; s >= 0; s--) begin
            if (v[s] && wa[s] == id_rs && id_rs != '0) begin
                rs_hit  = 1'b1;
                rs_tnew = tnew[s];
                rs_data = stage_wd[s*DW +: DW];
            end
            if (v[s] && wa[s] == id_rt && id_rt != '0) begin
                rt_hit  = 1'b1;
                rt_tnew = tnew[s];
                rt_data = stage_wd[s*DW +: DW];
            end
        end
    end

    assign md_busy  = (md_cnt != 8'd0);
    assign rs_term  = rs_hit && (id_rs_tuse != TUSE_NONE) && (rs_tnew > id_rs_tuse);
    assign rt_term  = rt_hit && (id_rt_tuse != TUSE_NONE) && (rt_tnew > id_rt_tuse);
    assign md_stall = id_md_use && md_busy;
    assign stall    = id_valid && (rs_term || rt_term || md_stall);

    // A match that is not ready yet falls back to the GRF value; a later forward covers it.
    assign id_rd1 = (rs_hit && rs_tnew == '0) ? rs_data : id_rd1_pre;
    assign id_rd2 = (rt_hit && rt_tnew == '0) ? rt_data : id_rd2_pre;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v      <= '0;
            md_cnt <= 8'd0;
            for (int s = 0; s < NSTAGE; s++) begin
                wa[s]   <= '0;
                tnew[s] <= '0;
            end
        end else if (flush) begin
            v      <= '0;
            md_cnt <= 8'd0;
        end else begin
            v[0]    <= id_valid && !stall && (id_wa != '0);
            wa[0]   <= id_wa;
            tnew[0] <= id_tnew;
            for (int s = 1; s < NSTAGE; s++) begin
                v[s]    <= v[s-1];
                wa[s]   <= wa[s-1];
                tnew[s] <= (tnew[s-1] != '0) ? tnew[s-1] - 1'b1 : '0;
            end
            if (id_valid && id_md_start && !stall)
                md_cnt <= 8'(MD_LAT);
            else if (md_cnt != 8'd0)
                md_cnt <= md_cnt - 8'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: in-flight write list model plus directed literal scenarios and random traffic.
module tb_hazard_scoreboard;

    localparam int NS  = 3;
    localparam int MDL = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          id_valid;
    logic [4:0]    id_rs, id_rt, id_wa;
    logic [1:0]    id_rs_tuse, id_rt_tuse, id_tnew;
    logic          id_md_start, id_md_use, flush;
    logic [95:0]   stage_wd;
    logic [31:0]   id_rd1_pre, id_rd2_pre;
    logic          stall, md_busy;
    logic [31:0]   id_rd1, id_rd2;

    logic          b_ov;
    logic [2:0]    b_rs_tuse, b_rt_tuse, b_tnew;
    logic [159:0]  b_stage_wd;
    logic          b_stall, b_md_busy;
    logic [31:0]   b_rd1, b_rd2;

    assign b_rs_tuse = (id_rs_tuse == 2'd3) ? 3'd7 : {1'b0, id_rs_tuse};
    assign b_rt_tuse = (id_rt_tuse == 2'd3) ? 3'd7 : {1'b0, id_rt_tuse};
    assign b_tnew    = b_ov ? 3'd4 : {1'b0, id_tnew};

    hazard_scoreboard #(.DW(32), .AW(5), .TW(2), .NSTAGE(NS), .MD_LAT(MDL)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_tuse(id_rs_tuse), .id_rt_tuse(id_rt_tuse), .id_wa(id_wa), .id_tnew(id_tnew),
        .id_md_start(id_md_start), .id_md_use(id_md_use), .flush(flush), .stage_wd(stage_wd),
        .id_rd1_pre(id_rd1_pre), .id_rd2_pre(id_rd2_pre), .stall(stall), .id_rd1(id_rd1),
        .id_rd2(id_rd2), .md_busy(md_busy)
    );

    hazard_scoreboard #(.DW(32), .AW(5), .TW(3), .NSTAGE(5), .MD_LAT(MDL)) dut_b (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_tuse(b_rs_tuse), .id_rt_tuse(b_rt_tuse), .id_wa(id_wa), .id_tnew(b_tnew),
        .id_md_start(id_md_start), .id_md_use(id_md_use), .flush(flush), .stage_wd(b_stage_wd),
        .id_rd1_pre(id_rd1_pre), .id_rd2_pre(id_rd2_pre), .stall(b_stall), .id_rd1(b_rd1),
        .id_rd2(b_rd2), .md_busy(b_md_busy)
    );

    always #5 clk = ~clk;

    // Model: list of in-flight writes; age = cycles since EX entry, current tnew = max(t0 - age, 0).
    typedef struct {
        logic [4:0] wa;
        int         t0;
        int         age;
    } wr_t;

    wr_t   q[$];
    int    md_rem;
    int    passed = 0;
    int    total  = 0;
    logic        exp_stall, exp_busy;
    logic [31:0] exp_rd1, exp_rd2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        else passed++;
    endtask

    task automatic find(input logic [4:0] op, output bit hit, output int tn, output int st);
        hit = 1'b0;
        tn  = 0;
        st  = 0;
        if (op != 5'd0) begin
            foreach (q[i]) begin
                if (q[i].wa == op && (!hit || q[i].age < st)) begin
                    hit = 1'b1;
                    st  = q[i].age;
                    tn  = (q[i].t0 > q[i].age) ? q[i].t0 - q[i].age : 0;
                end
            end
        end
    endtask

    task automatic eval();
        bit h1, h2;
        int t1, t2, s1, s2;
        bit rs_s, rt_s;
        find(id_rs, h1, t1, s1);
        find(id_rt, h2, t2, s2);
        rs_s      = h1 && id_rs_tuse != 2'd3 && t1 > int'(id_rs_tuse);
        rt_s      = h2 && id_rt_tuse != 2'd3 && t2 > int'(id_rt_tuse);
        exp_busy  = (md_rem > 0);
        exp_stall = id_valid && (rs_s || rt_s || (id_md_use && exp_busy));
        exp_rd1   = (h1 && t1 == 0) ? stage_wd[s1*32 +: 32] : id_rd1_pre;
        exp_rd2   = (h2 && t2 == 0) ? stage_wd[s2*32 +: 32] : id_rd2_pre;
    endtask

    task automatic settle();
        @(negedge clk);
        eval();
        chk("stall", stall, exp_stall);
        chk("id_rd1", id_rd1, exp_rd1);
        chk("id_rd2", id_rd2, exp_rd2);
        chk("md_busy", md_busy, exp_busy);
    endtask

    task automatic tick();
        wr_t nq[$];
        @(posedge clk);
        if (!reset_n || flush) begin
            q.delete();
            md_rem = 0;
        end else begin
            foreach (q[i])
                if (q[i].age + 1 < NS) nq.push_back('{q[i].wa, q[i].t0, q[i].age + 1});
            if (id_valid && !exp_stall && id_wa != 5'd0) nq.push_front('{id_wa, int'(id_tnew), 0});
            q = nq;
            if (id_valid && id_md_start && !exp_stall) md_rem = MDL;
            else if (md_rem > 0) md_rem--;
        end
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_wa = 5'd0;
        id_rs_tuse = 2'd3; id_rt_tuse = 2'd3; id_tnew = 2'd0;
        id_md_start = 1'b0; id_md_use = 1'b0; flush = 1'b0; b_ov = 1'b0;
    endtask

    task automatic issue(input logic [4:0] wa, input logic [1:0] tn);
        idle(); id_valid = 1'b1; id_wa = wa; id_tnew = tn;
    endtask

    task automatic read_rs(input logic [4:0] rs, input logic [1:0] tuse);
        idle(); id_valid = 1'b1; id_rs = rs; id_rs_tuse = tuse;
    endtask

    task automatic mult();
        idle(); id_valid = 1'b1; id_md_start = 1'b1; id_md_use = 1'b1;
    endtask

    initial begin
        q.delete();
        md_rem = 0;
        idle();
        stage_wd   = {32'h2222_2222, 32'hDEAD_BEEF, 32'hAAAA_AAAA};
        for (int s = 0; s < 5; s++) b_stage_wd[s*32 +: 32] = 32'hB000_0000 + s;
        id_rd1_pre = 32'h1111_0001;
        id_rd2_pre = 32'h1111_0002;
        reset_n    = 1'b0;
        #2;
        chk("rst_stall", stall, 1'b0);
        chk("rst_busy", md_busy, 1'b0);
        chk("rst_rd1", id_rd1, 32'h1111_0001);
        chk("rst_rd2", id_rd2, 32'h1111_0002);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // load $1 tnew=2 then a tuse=0 reader: two stall cycles, then WB slice forwards
        issue(5'd1, 2'd2); settle(); tick();
        read_rs(5'd1, 2'd0);
        settle(); chk("s1_stall_a", stall, 1'b1); tick();
        settle(); chk("s1_stall_b", stall, 1'b1); tick();
        settle(); chk("s1_go", stall, 1'b0); chk("s1_fwd", id_rd1, 32'h2222_2222); tick();

        // ALU $5 tnew=1, reader tuse=1: no stall, then forwards once tnew reaches 0
        issue(5'd5, 2'd1); settle(); tick();
        idle(); id_valid = 1'b1; id_rt = 5'd5; id_rt_tuse = 2'd1;
        settle(); chk("s2_nostall", stall, 1'b0); chk("s2_pre", id_rd2, 32'h1111_0002); tick();
        settle(); chk("s2_fwd", id_rd2, 32'hDEAD_BEEF); tick();

        // two writers to $3: youngest wins; $0 never matches
        issue(5'd3, 2'd0); settle(); tick();
        issue(5'd3, 2'd0); settle(); tick();
        read_rs(5'd3, 2'd0);
        settle(); chk("s3_young", id_rd1, 32'hAAAA_AAAA); chk("s3_stall", stall, 1'b0); tick();
        read_rs(5'd0, 2'd0);
        settle(); chk("s3_zero", id_rd1, 32'h1111_0001); chk("s3_zstall", stall, 1'b0); tick();

        // mult: five busy cycles stall an mfhi, sixth proceeds as a second mult that reloads
        mult(); settle(); tick();
        idle(); id_valid = 1'b1; id_md_use = 1'b1;
        for (int k = 0; k < MDL; k++) begin
            settle(); chk("s4_stall", stall, 1'b1); chk("s4_busy", md_busy, 1'b1); tick();
        end
        mult();
        settle(); chk("s4_go", stall, 1'b0); chk("s4_free", md_busy, 1'b0); tick();
        idle();
        for (int k = 0; k < MDL; k++) begin
            settle(); chk("s4_reload", md_busy, 1'b1); tick();
        end
        settle(); chk("s4_done", md_busy, 1'b0); tick();

        // flush while stalled
        mult(); settle(); tick();
        issue(5'd2, 2'd2); settle(); tick();
        read_rs(5'd2, 2'd0); flush = 1'b1;
        settle(); chk("s5_pre_stall", stall, 1'b1); chk("s5_pre_busy", md_busy, 1'b1); tick();
        flush = 1'b0;
        settle(); chk("s5_stall", stall, 1'b0); chk("s5_busy", md_busy, 1'b0);
        chk("s5_rd1", id_rd1, 32'h1111_0001); tick();

        // asynchronous reset between edges
        mult(); settle(); tick();
        issue(5'd1, 2'd2); settle(); tick();
        read_rs(5'd1, 2'd0);
        settle(); chk("s6_stall", stall, 1'b1);
        #2 reset_n = 1'b0;
        q.delete(); md_rem = 0;
        #1;
        chk("s6_stall0", stall, 1'b0); chk("s6_busy0", md_busy, 1'b0);
        chk("s6_b_stall0", b_stall, 1'b0); chk("s6_b_busy0", b_md_busy, 1'b0);
        reset_n = 1'b1;
        eval();
        tick();

        // NSTAGE=5/TW=3 instance: tnew=4 writer stalls 4 cycles, then WB slice 4 forwards
        idle(); flush = 1'b1; settle(); tick();
        issue(5'd1, 2'd2); b_ov = 1'b1; settle(); tick();
        read_rs(5'd1, 2'd0);
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("s7_b_stall", b_stall, 1'b1);
            chk("s7_a_stall", stall, (k < 2) ? 1'b1 : 1'b0);
            if (k == 2) chk("s7_a_fwd", id_rd1, 32'h2222_2222);
            if (k == 3) chk("s7_a_retired", id_rd1, 32'h1111_0001);
            tick();
        end
        settle(); chk("s7_b_go", b_stall, 1'b0); chk("s7_b_fwd", b_rd1, 32'hB000_0004); tick();

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            id_valid    = ($urandom_range(0, 9) < 8);
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            id_wa       = 5'($urandom_range(0, 3));
            id_rs_tuse  = 2'($urandom_range(0, 3));
            id_rt_tuse  = 2'($urandom_range(0, 3));
            id_tnew     = 2'($urandom_range(0, 3));
            id_md_start = ($urandom_range(0, 15) == 0);
            id_md_use   = id_md_start | ($urandom_range(0, 7) == 0);
            flush       = ($urandom_range(0, 39) == 0);
            stage_wd    = {$urandom, $urandom, $urandom};
            id_rd1_pre  = $urandom;
            id_rd2_pre  = $urandom;
            settle();
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
